// File: rtl/matrix_bus_pkg.sv
// Shared definitions for the 4-bit matrix load bus: widths, transmitter states
// and the header field order that the loader relies on.
package matrix_bus_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int DIM_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      M1,
      M2
   } tx_state_t;

   typedef logic [1:0] hdr_idx_t;

   // Header nibble order on the bus; the loader decodes dims in this order.
   localparam hdr_idx_t HDR_R1 = 2'd0;
   localparam hdr_idx_t HDR_C1 = 2'd1;
   localparam hdr_idx_t HDR_R2 = 2'd2;
   localparam hdr_idx_t HDR_C2 = 2'd3;

   localparam int HDR_WORDS = 4;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col address counter with clear, enable and a last-element flag.
// Wrapping from the last element back to (0,0) lets it roll straight into the next matrix.
module matrix_index_counter #(
   parameter int DIM_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clear,
   input  logic             en,
   input  logic [DIM_W-1:0] rows,
   input  logic [DIM_W-1:0] cols,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last
);

   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   logic col_end;
   logic row_end;

   assign col_end = (col == (cols - ONE));
   assign row_end = (row == (rows - ONE));
   assign last    = col_end && row_end;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end

endmodule

// File: rtl/matrix_frame_tx.sv
// Transmit side of the matrix load bus: sends the R1,C1,R2,C2 header and then
// streams both matrices row-major from a valid/ready element source.
import matrix_bus_pkg::*;

module matrix_frame_tx #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic [DIM_W-1:0]  r1,
   input  logic [DIM_W-1:0]  c1,
   input  logic [DIM_W-1:0]  r2,
   input  logic [DIM_W-1:0]  c2,
   input  logic [DATA_W-1:0] elem_data,
   input  logic              elem_valid,
   output logic              elem_ready,
   output logic              elem_sel,
   output logic [DIM_W-1:0]  elem_row,
   output logic [DIM_W-1:0]  elem_col,
   output logic [DATA_W-1:0] data,
   output logic              ctrl_logic,
   output logic              dvalid,
   output logic              busy,
   output logic              done
);

   tx_state_t        state;
   hdr_idx_t         hdr_idx;
   logic [DIM_W-1:0] r1_q;
   logic [DIM_W-1:0] c1_q;
   logic [DIM_W-1:0] r2_q;
   logic [DIM_W-1:0] c2_q;
   logic [DIM_W-1:0] hdr_dim;
   logic [DIM_W-1:0] cur_rows;
   logic [DIM_W-1:0] cur_cols;
   logic             m1_empty;
   logic             m2_empty;
   logic             accept;
   logic             last_elem;

   assign m1_empty   = (r1_q == '0) || (c1_q == '0);
   assign m2_empty   = (r2_q == '0) || (c2_q == '0);
   assign elem_ready = (state == M1) || (state == M2);
   assign accept     = elem_valid && elem_ready;

   // One counter serves both matrices; elem_sel picks whose dims bound it.
   assign cur_rows = elem_sel ? r2_q : r1_q;
   assign cur_cols = elem_sel ? c2_q : c1_q;

   always_comb begin
      hdr_dim = r1_q;
      case (hdr_idx)
         HDR_R1:  hdr_dim = r1_q;
         HDR_C1:  hdr_dim = c1_q;
         HDR_R2:  hdr_dim = r2_q;
         HDR_C2:  hdr_dim = c2_q;
         default: hdr_dim = r1_q;
      endcase
   end

   matrix_index_counter #(
      .DIM_W (DIM_W)
   ) u_index (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clear (state == IDLE),
      .en    (accept),
      .rows  (cur_rows),
      .cols  (cur_cols),
      .row   (elem_row),
      .col   (elem_col),
      .last  (last_elem)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         hdr_idx    <= HDR_R1;
         r1_q       <= '0;
         c1_q       <= '0;
         r2_q       <= '0;
         c2_q       <= '0;
         data       <= '0;
         ctrl_logic <= 1'b0;
         dvalid     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         elem_sel   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dvalid     <= 1'b0;
               ctrl_logic <= 1'b0;
               done       <= 1'b0;
               elem_sel   <= 1'b0;
               if (start) begin
                  r1_q    <= r1;
                  c1_q    <= c1;
                  r2_q    <= r2;
                  c2_q    <= c2;
                  hdr_idx <= HDR_R1;
                  busy    <= 1'b1;
                  state   <= HDR;
               end
            end

            HDR: begin
               data       <= DATA_W'(hdr_dim);
               ctrl_logic <= 1'b1;
               dvalid     <= 1'b1;
               hdr_idx    <= hdr_idx + 2'd1;
               // Empty matrices are skipped right after the last header nibble.
               if (hdr_idx == HDR_C2) begin
                  if (!m1_empty) begin
                     state <= M1;
                  end else if (!m2_empty) begin
                     state    <= M2;
                     elem_sel <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end

            M1, M2: begin
               if (accept) begin
                  data       <= elem_data;
                  ctrl_logic <= 1'b0;
                  dvalid     <= 1'b1;
                  if (last_elem) begin
                     if ((state == M1) && !m2_empty) begin
                        state    <= M2;
                        elem_sel <= 1'b1;
                     end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        elem_sel <= 1'b0;
                     end
                  end
               end else begin
                  dvalid     <= 1'b0;
                  ctrl_logic <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_frame_tx.sv
// Scoreboard bench for matrix_frame_tx: a frame-level model queues the expected
// words and addresses, and a monitor pops and compares whatever the DUT emits.
module tb_matrix_frame_tx;
   import matrix_bus_pkg::*;

   localparam int DATA_W = 4;
   localparam int DIM_W  = 4;

   logic              CLK;
   logic              RST_N;
   logic              start;
   logic [DIM_W-1:0]  r1, c1, r2, c2;
   logic [DATA_W-1:0] elem_data;
   logic              elem_valid;
   logic              elem_ready;
   logic              elem_sel;
   logic [DIM_W-1:0]  elem_row;
   logic [DIM_W-1:0]  elem_col;
   logic [DATA_W-1:0] data;
   logic              ctrl_logic;
   logic              dvalid;
   logic              busy;
   logic              done;

   matrix_frame_tx #(
      .DATA_W (DATA_W),
      .DIM_W  (DIM_W)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .r1         (r1),
      .c1         (c1),
      .r2         (r2),
      .c2         (c2),
      .elem_data  (elem_data),
      .elem_valid (elem_valid),
      .elem_ready (elem_ready),
      .elem_sel   (elem_sel),
      .elem_row   (elem_row),
      .elem_col   (elem_col),
      .data       (data),
      .ctrl_logic (ctrl_logic),
      .dvalid     (dvalid),
      .busy       (busy),
      .done       (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic              ctrl;
      logic [DATA_W-1:0] val;
   } word_t;

   word_t               exp_q[$];
   logic [DATA_W-1:0]   src_q[$];
   logic [2*DIM_W:0]    addr_q[$];

   int checks = 0;
   int errors = 0;

   int total_words = 0;
   int total_done  = 0;
   int total_gap   = 0;
   int edge_cnt    = 0;

   int frame_base_words = 0;
   int start_edge       = 0;
   bit strict_timing    = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      edge_cnt++;
   end

   // Monitor: addresses are checked while the DUT requests, words whenever dvalid is high.
   initial forever begin
      word_t w;
      int    widx;
      @(negedge CLK);
      if (RST_N) begin
         if (elem_ready) begin
            checkOutput("addr_pending", 32'(addr_q.size() > 0), 1);
            if (addr_q.size() > 0) begin
               checkOutput("elem_addr", {elem_sel, elem_row, elem_col}, addr_q[0]);
               if (elem_valid) void'(addr_q.pop_front());
            end
         end
         if (done) total_done++;
         if (dvalid) begin
            total_words++;
            checkOutput("word_available", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               checkOutput("word", {ctrl_logic, data}, w);
               checkOutput("done_on_last", done, 32'(exp_q.size() == 0));
               checkOutput("busy_with_word", busy, 32'(exp_q.size() != 0));
               widx = total_words - 1 - frame_base_words;
               if (widx < HDR_WORDS || strict_timing)
                  checkOutput("word_timing", edge_cnt - start_edge, widx + 1);
            end
         end else begin
            checkOutput("idle_ctrl", ctrl_logic, 0);
            checkOutput("idle_done", done, 0);
            if (busy && (total_words > frame_base_words)) total_gap++;
         end
      end
   end

   task automatic flushModel();
      exp_q.delete();
      src_q.delete();
      addr_q.delete();
   endtask

   // Reference: header nibbles, then both matrices row-major as plain nested loops.
   task automatic applyStimulus(input int r1v, input int c1v, input int r2v, input int c2v,
                                input int gap_pct, input bit seq_vals,
                                input int stall_after, input int stall_len,
                                input int poke_cycle, input int abort_cycle, input int exp_gap);
      int                dims[4];
      int                rows, cols, k, cyc, acc_cnt, stall_left, exp_words;
      int                done_base, gap_base;
      bit                will_acc;
      logic [DATA_W-1:0] v;
      logic [DIM_W-1:0]  rr, cc;
      dims = '{r1v, c1v, r2v, c2v};
      for (int i = 0; i < HDR_WORDS; i++) exp_q.push_back({1'b1, DATA_W'(dims[i])});
      k = 0;
      for (int m = 0; m < 2; m++) begin
         rows = (m == 0) ? r1v : r2v;
         cols = (m == 0) ? c1v : c2v;
         for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
               k++;
               v  = seq_vals ? DATA_W'(k) : DATA_W'($urandom_range(15));
               rr = DIM_W'(r);
               cc = DIM_W'(c);
               src_q.push_back(v);
               exp_q.push_back({1'b0, v});
               addr_q.push_back({(m == 1), rr, cc});
            end
         end
      end
      exp_words        = exp_q.size();
      frame_base_words = total_words;
      done_base        = total_done;
      gap_base         = total_gap;
      strict_timing    = (gap_pct == 0) && (stall_len == 0);

      start      = 1'b1;
      r1         = DIM_W'(r1v);
      c1         = DIM_W'(c1v);
      r2         = DIM_W'(r2v);
      c2         = DIM_W'(c2v);
      elem_valid = 1'b0;
      @(posedge CLK);
      #1;
      start_edge = edge_cnt;
      start      = 1'b0;
      r1         = DIM_W'($urandom_range(15));
      c1         = DIM_W'($urandom_range(15));
      r2         = DIM_W'($urandom_range(15));
      c2         = DIM_W'($urandom_range(15));
      elem_valid = (src_q.size() > 0);
      elem_data  = (src_q.size() > 0) ? src_q[0] : DATA_W'($urandom_range(15));

      cyc        = 0;
      acc_cnt    = 0;
      stall_left = 0;
      while ((total_done == done_base) && (cyc < 3000) && (cyc != abort_cycle)) begin
         @(negedge CLK);
         will_acc = elem_valid && elem_ready;
         @(posedge CLK);
         #1;
         cyc++;
         if (will_acc && (src_q.size() > 0)) begin
            void'(src_q.pop_front());
            acc_cnt++;
            if (acc_cnt == stall_after) stall_left = stall_len;
         end
         start = (cyc == poke_cycle);
         if (start) begin
            r1 = DIM_W'($urandom_range(1, 15));
            c1 = DIM_W'($urandom_range(1, 15));
         end
         if (stall_left > 0) begin
            elem_valid = 1'b0;
            stall_left--;
         end else begin
            elem_valid = (src_q.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
         end
         elem_data = (src_q.size() > 0) ? src_q[0] : DATA_W'($urandom_range(15));
      end
      start      = 1'b0;
      elem_valid = 1'b0;

      if (cyc != abort_cycle) begin
         checkOutput("frame_completed", 32'(total_done != done_base), 1);
         repeat (3) @(posedge CLK);
         #1;
         checkOutput("done_once", total_done - done_base, 1);
         checkOutput("word_count", total_words - frame_base_words, exp_words);
         checkOutput("scoreboard_drained", exp_q.size() + addr_q.size(), 0);
         if (exp_gap >= 0) checkOutput("stall_cycles", total_gap - gap_base, exp_gap);
         flushModel();
      end
   endtask

   // Reset lands mid-cycle; every output must clear without waiting for a clock.
   task automatic resetMidCycle();
      #3;
      RST_N = 1'b0;
      #1;
      checkOutput("reset_outputs",
                  {data, ctrl_logic, dvalid, busy, done, elem_ready, elem_sel, elem_row, elem_col}, 0);
      flushModel();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("post_reset_idle", {dvalid, busy, done, elem_ready}, 0);
   endtask

   initial begin
      RST_N      = 1'b1;
      start      = 1'b0;
      r1         = '0;
      c1         = '0;
      r2         = '0;
      c2         = '0;
      elem_data  = '0;
      elem_valid = 1'b0;
      @(posedge CLK);
      resetMidCycle();

      applyStimulus(2, 2, 2, 2, 0, 1'b1, -1, 0, -1, -1, 0);
      applyStimulus(1, 3, 1, 1, 0, 1'b1, 2, 2, -1, -1, 2);
      applyStimulus(0, 3, 1, 2, 0, 1'b0, -1, 0, -1, -1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1'b0, -1, 0, -1, -1, 0);
      applyStimulus(2, 3, 2, 2, 0, 1'b0, -1, 0, 5, -1, 0);

      applyStimulus(3, 3, 2, 2, 0, 1'b0, -1, 0, -1, 8, -1);
      resetMidCycle();
      applyStimulus(2, 1, 1, 2, 0, 1'b0, -1, 0, -1, -1, 0);

      applyStimulus(15, 15, 15, 15, 30, 1'b0, -1, 0, -1, -1, -1);
      for (int n = 0; n < 4; n++)
         applyStimulus($urandom_range(5), $urandom_range(5), $urandom_range(5), $urandom_range(5),
                       20, 1'b0, -1, 0, -1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
